lcd_power_seq: RTL
==================

// Module: lcd_power_seq
// PURPOSE
//  Power-up/power-down sequencer for the RGB LCD path. Drives panel power, releases the
//  sync generator's active-low reset, confirms VSYNC activity, then ramps backlight PWM.
//  Reverses the order on shutdown. Sits between top-level enable logic and the sync
//  generator / backlight pin.
// PARAMETERS
//  PWR_DLY_CYC   1000     cycles between LCD_PWR rise and SYNC_RST_N release (also on power-down)
//  SYNC_FRAMES   2        VSYNC rising edges required before backlight ramp starts (>=1)
//  RAMP_STEP_CYC 256      cycles per +/-1 backlight level step during ramps (>=1)
//  PWM_BITS      8        backlight level / PWM counter width
//  VS_TIMEOUT    1048576  max cycles in SYNC_WAIT without a VSYNC rising edge before FAULT
// PORTS
//  CLK         in   1         pixel clock
//  RST_IN      in   1         synchronous reset, active-low
//  EN          in   1         1 = display requested on, 0 = off
//  BRIGHTNESS  in   PWM_BITS  target backlight level
//  LCD_VSYNC   in   1         VSYNC from sync generator (active-low pulse)
//  LCD_PWR     out  1         panel power enable
//  SYNC_RST_N  out  1         to sync generator RST_IN; 0 holds it in reset
//  LCD_PWM     out  1         backlight PWM
//  READY       out  1         1 only in ON state
//  FAULT       out  1         1 only in FAULT state
// BEHAVIOUR
//  - All outputs registered. RST_IN=0 on a CLK edge: state OFF, all outputs 0, level=0,
//    all counters 0; applies mid-sequence, no graceful ramp-down.
//  - States / transitions (evaluated each CLK edge, outputs reflect new state next cycle):
//    OFF:       PWR=0,SRN=0. EN=1 -> PWR_WAIT.
//    PWR_WAIT:  PWR=1,SRN=0. After PWR_DLY_CYC cycles -> SYNC_WAIT. EN=0 -> OFF.
//    SYNC_WAIT: PWR=1,SRN=1. Count VSYNC rising edges (registered edge detect, prev sample
//               reset to 1). At SYNC_FRAMES edges -> BL_RAMP. VS_TIMEOUT cycles since entry
//               or since last edge -> FAULT. EN=0 -> OFF.
//    BL_RAMP:   level += 1 every RAMP_STEP_CYC cycles while level < BRIGHTNESS; level >=
//               BRIGHTNESS -> ON (immediate if BRIGHTNESS<=level on entry). EN=0 -> BL_DOWN.
//    ON:        READY=1; level <= BRIGHTNESS every cycle (no ramp). EN=0 -> BL_DOWN.
//    BL_DOWN:   level -= 1 every RAMP_STEP_CYC cycles; level==0 -> SYNC_OFF. EN=1 -> BL_RAMP
//               (ramps up from current level, no restart of power sequence).
//    SYNC_OFF:  SRN=0,PWR=1 for PWR_DLY_CYC cycles -> OFF. EN ignored.
//    FAULT:     PWR=0,SRN=0,PWM=0,FAULT=1. EN=0 -> OFF. EN held 1 stays in FAULT.
//  - Step/delay counters clear on every state change.
//  - PWM: free-running PWM_BITS counter pc (counts in all states, wraps 2^PWM_BITS-1 -> 0).
//    Active duty register duty latches level when pc==2^PWM_BITS-1 (glitch-free update).
//    LCD_PWM = (pc < duty) registered, forced 0 in OFF, PWR_WAIT, SYNC_WAIT, SYNC_OFF, FAULT.
//    Duty = duty/2^PWM_BITS; level max gives (2^PWM_BITS-1)/2^PWM_BITS, never 100%.
//  - Level arithmetic saturates: never below 0, never above 2^PWM_BITS-1.
// TESTING (params PWR_DLY_CYC=10, SYNC_FRAMES=2, RAMP_STEP_CYC=4, PWM_BITS=4, VS_TIMEOUT=100)
//  1. Reset, EN=1, BRIGHTNESS=3, VSYNC toggling every 20 cyc -> PWR=1, SRN=1 10 cyc later,
//     ramp after 2nd rising edge, level 1,2,3 at 4-cyc steps, READY=1, PWM 3 of 16 high.
//  2. From ON drop EN -> level steps 3,2,1,0 every 4 cyc, then SRN=0, PWR=0 10 cyc later,
//     READY=0 in cycle after EN sampled 0.
//  3. VSYNC held high in SYNC_WAIT -> FAULT=1, PWR=0 after 100 cyc; EN=0 -> OFF, FAULT=0.
//  4. EN=0 mid BL_DOWN at level 2, EN=1 again -> returns to BL_RAMP from 2, reaches ON
//     without PWR or SRN dropping.
//  5. BRIGHTNESS 3->12 while ON mid PWM period -> PWM width changes only after pc wraps.
//  6. RST_IN=0 for 1 cyc during BL_RAMP -> all outputs 0 next cycle, state OFF; EN=1 restarts.

Source files
------------

// File: rtl/lcd_power_seq.sv
// Power sequencer for the RGB LCD path: panel power, sync-generator reset release,
// VSYNC confirmation and backlight ramp on the way up, reversed on the way down.
module lcd_power_seq #(
  parameter int unsigned PWR_DLY_CYC   = 1000,
  parameter int unsigned SYNC_FRAMES   = 2,
  parameter int unsigned RAMP_STEP_CYC = 256,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned VS_TIMEOUT    = 1048576
) (
  input  logic                CLK,
  input  logic                RST_IN,
  input  logic                EN,
  input  logic [PWM_BITS-1:0] BRIGHTNESS,
  input  logic                LCD_VSYNC,
  output logic                LCD_PWR,
  output logic                SYNC_RST_N,
  output logic                LCD_PWM,
  output logic                READY,
  output logic                FAULT
);

  localparam int unsigned DLY_MAX = (PWR_DLY_CYC > RAMP_STEP_CYC) ? PWR_DLY_CYC : RAMP_STEP_CYC;
  localparam int unsigned CNT_MAX = (VS_TIMEOUT > DLY_MAX) ? VS_TIMEOUT : DLY_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGE_W  = $clog2(SYNC_FRAMES + 1);

  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [CNT_W-1:0]    PWR_LAST  = CNT_W'(PWR_DLY_CYC - 1);
  localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(RAMP_STEP_CYC - 1);
  localparam logic [CNT_W-1:0]    TMO_LAST  = CNT_W'(VS_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0]   EDGE_LAST = EDGE_W'(SYNC_FRAMES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_WAIT,
    S_SYNC_WAIT,
    S_BL_RAMP,
    S_ON,
    S_BL_DOWN,
    S_SYNC_OFF,
    S_FAULT
  } state_t;

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [EDGE_W-1:0]   edges_q,   edges_d;
  logic [PWM_BITS-1:0] level_q,   level_d;
  logic                vs_prev_q, vs_prev_d;
  logic [PWM_BITS-1:0] pc_q,      pc_d;
  logic [PWM_BITS-1:0] duty_q,    duty_d;
  logic                pwr_q,     pwr_d;
  logic                srn_q,     srn_d;
  logic                pwm_q,     pwm_d;
  logic                ready_q,   ready_d;
  logic                fault_q,   fault_d;
  logic                rise_c;

  // Sequencer: state transitions, delay/step counting and backlight level
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edges_d   = edges_q;
    level_d   = level_q;
    vs_prev_d = LCD_VSYNC;
    rise_c    = LCD_VSYNC & ~vs_prev_q;

    case (state_q)
      S_OFF: begin
        if (EN) state_d = S_PWR_WAIT;
      end
      S_PWR_WAIT: begin
        if (!EN)                    state_d = S_OFF;
        else if (cnt_q == PWR_LAST) state_d = S_SYNC_WAIT;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_SYNC_WAIT: begin
        // an edge both counts a frame and restarts the timeout window
        if (!EN)                                  state_d = S_OFF;
        else if (rise_c && edges_q == EDGE_LAST)  state_d = S_BL_RAMP;
        else if (rise_c) begin
          edges_d = edges_q + EDGE_W'(1);
          cnt_d   = '0;
        end
        else if (cnt_q == TMO_LAST)               state_d = S_FAULT;
        else                                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_BL_RAMP: begin
        if (!EN)                        state_d = S_BL_DOWN;
        else if (level_q >= BRIGHTNESS) state_d = S_ON;
        else if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          level_d = (level_q == LVL_MAX) ? level_q : level_q + PWM_BITS'(1);
        end
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
      S_ON: begin
        level_d = BRIGHTNESS;
        if (!EN) state_d = S_BL_DOWN;
      end
      S_BL_DOWN: begin
        if (EN)                    state_d = S_BL_RAMP;
        else if (level_q == '0)    state_d = S_SYNC_OFF;
        else if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          level_d = level_q - PWM_BITS'(1);
        end
        else                       cnt_d   = cnt_q + CNT_W'(1);
      end
      S_SYNC_OFF: begin
        if (cnt_q == PWR_LAST) state_d = S_OFF;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FAULT: begin
        if (!EN) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    if (state_d != state_q) begin
      cnt_d   = '0;
      edges_d = '0;
    end
  end

  // Output decode from the next state, plus the glitch-free PWM datapath
  always_comb begin
    pwr_d   = (state_d != S_OFF) && (state_d != S_FAULT);
    srn_d   = state_d inside {S_SYNC_WAIT, S_BL_RAMP, S_ON, S_BL_DOWN};
    ready_d = (state_d == S_ON);
    fault_d = (state_d == S_FAULT);

    pc_d    = pc_q + PWM_BITS'(1);
    duty_d  = (pc_q == LVL_MAX) ? level_q : duty_q;
    pwm_d   = (state_d inside {S_BL_RAMP, S_ON, S_BL_DOWN}) && (pc_q < duty_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_IN) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      edges_q   <= '0;
      level_q   <= '0;
      vs_prev_q <= 1'b1;
      pc_q      <= '0;
      duty_q    <= '0;
      pwr_q     <= 1'b0;
      srn_q     <= 1'b0;
      pwm_q     <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edges_q   <= edges_d;
      level_q   <= level_d;
      vs_prev_q <= vs_prev_d;
      pc_q      <= pc_d;
      duty_q    <= duty_d;
      pwr_q     <= pwr_d;
      srn_q     <= srn_d;
      pwm_q     <= pwm_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign LCD_PWR    = pwr_q;
  assign SYNC_RST_N = srn_q;
  assign LCD_PWM    = pwm_q;
  assign READY      = ready_q;
  assign FAULT      = fault_q;

endmodule
